// File: rtl/exec_wb_stage.sv
// Execute-to-writeback stage: two-entry skid buffer toward the register file,
// architectural {S,Z,C,V} flag register, branch condition evaluation and retire counter.
module exec_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  N_RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_W-1:0]     ALU_RESULT,
  input  logic [3:0]            FLAG_IN,
  input  logic [3:0]            S_ALU,
  input  logic [REG_ADDR_W-1:0] RD_ADDR,
  input  logic                  RD_WE,
  input  logic                  FLAG_WE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_W-1:0]     WB_DATA,
  output logic [REG_ADDR_W-1:0] WB_ADDR,
  output logic                  WB_WE,
  output logic [3:0]            FLAG_REG,
  input  logic [2:0]            COND,
  output logic                  COND_TRUE,
  output logic [CNT_W-1:0]      RETIRE_CNT
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0]     main_data_reg, skid_data_reg;
  logic [REG_ADDR_W-1:0] main_addr_reg, skid_addr_reg;
  logic                  main_we_reg, skid_we_reg;
  logic [3:0]            flag_reg;
  logic [CNT_W-1:0]      retire_cnt_reg;

  logic accept, pop;
  logic load_main_in, load_skid, load_main_skid;
  logic sign_xor_ovf;

  assign accept = IN_VALID & IN_READY;
  assign pop    = OUT_VALID & OUT_READY;

  // Main takes the input when it is (or is becoming) free; otherwise the skid catches it.
  assign load_main_in   = accept & ((state_reg == EMPTY) | ((state_reg == ONE) & pop));
  assign load_skid      = accept & (state_reg == ONE) & ~pop;
  assign load_main_skid = (state_reg == TWO) & pop;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = TWO;
        else if (!accept && pop) state_next = EMPTY;
      end
      TWO:     if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    IN_READY  = (state_reg != TWO);
    OUT_VALID = (state_reg != EMPTY);
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      main_data_reg  <= '0;
      main_addr_reg  <= '0;
      main_we_reg    <= 1'b0;
      skid_data_reg  <= '0;
      skid_addr_reg  <= '0;
      skid_we_reg    <= 1'b0;
      flag_reg       <= 4'b0000;
      retire_cnt_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_data_reg <= ALU_RESULT;
        main_addr_reg <= RD_ADDR;
        main_we_reg   <= RD_WE;
      end else if (load_main_skid) begin
        main_data_reg <= skid_data_reg;
        main_addr_reg <= skid_addr_reg;
        main_we_reg   <= skid_we_reg;
      end
      if (load_skid) begin
        skid_data_reg <= ALU_RESULT;
        skid_addr_reg <= RD_ADDR;
        skid_we_reg   <= RD_WE;
      end
      // Flags commit at accept so a branch right behind the op sees them.
      if (accept && FLAG_WE && (S_ALU != 4'b1111)) begin
        flag_reg <= FLAG_IN;
      end
      if (pop) begin
        retire_cnt_reg <= retire_cnt_reg + 1'b1;
      end
    end
  end

  assign WB_DATA    = main_data_reg;
  assign WB_ADDR    = main_addr_reg;
  assign WB_WE      = OUT_VALID & main_we_reg;
  assign FLAG_REG   = flag_reg;
  assign RETIRE_CNT = retire_cnt_reg;

  // Flag bit order is {S,Z,C,V}.
  assign sign_xor_ovf = flag_reg[3] ^ flag_reg[0];

  always_comb begin
    COND_TRUE = 1'b0;
    case (COND)
      3'b000: COND_TRUE = 1'b1;
      3'b001: COND_TRUE = flag_reg[2];
      3'b010: COND_TRUE = ~flag_reg[2];
      3'b011: COND_TRUE = sign_xor_ovf;
      3'b100: COND_TRUE = ~sign_xor_ovf;
      3'b101: COND_TRUE = flag_reg[2] | sign_xor_ovf;
      3'b110: COND_TRUE = ~flag_reg[2] & ~sign_xor_ovf;
      3'b111: COND_TRUE = flag_reg[1];
      default: COND_TRUE = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_wb_stage.sv
// Bench for exec_wb_stage: scoreboard on the writeback port, table of flag/condition
// vectors, and hand sequences for backpressure, reset-in-TWO and counter wrap.
module tb_exec_wb_stage;

  logic        CLK;
  logic        N_RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] ALU_RESULT;
  logic [3:0]  FLAG_IN;
  logic [3:0]  S_ALU;
  logic [2:0]  RD_ADDR;
  logic        RD_WE;
  logic        FLAG_WE;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] WB_DATA;
  logic [2:0]  WB_ADDR;
  logic        WB_WE;
  logic [3:0]  FLAG_REG;
  logic [2:0]  COND;
  logic        COND_TRUE;
  logic [15:0] RETIRE_CNT;

  exec_wb_stage dut (
    .CLK(CLK), .N_RST(N_RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_RESULT(ALU_RESULT), .FLAG_IN(FLAG_IN), .S_ALU(S_ALU), .RD_ADDR(RD_ADDR),
    .RD_WE(RD_WE), .FLAG_WE(FLAG_WE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .WB_DATA(WB_DATA), .WB_ADDR(WB_ADDR), .WB_WE(WB_WE), .FLAG_REG(FLAG_REG),
    .COND(COND), .COND_TRUE(COND_TRUE), .RETIRE_CNT(RETIRE_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  addr;
    logic        we;
  } wb_t;

  wb_t sb[$];

  typedef struct {
    logic [3:0] flag_in;
    logic       flag_we;
    logic [3:0] s_alu;
    logic [2:0] cond;
    logic [3:0] exp_flags;
    logic       exp_cond;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: compare each popped entry against the oldest accepted one.
  always @(negedge CLK) begin
    wb_t exp_e;
    if (!N_RST) begin
      sb.delete();
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_pop", {15'd0, OUT_VALID}, 32'd0);
        end else begin
          exp_e = sb.pop_front();
          check("sb_wb_data", {16'd0, WB_DATA}, {16'd0, exp_e.data});
          check("sb_wb_addr", {29'd0, WB_ADDR}, {29'd0, exp_e.addr});
          check("sb_wb_we", {31'd0, WB_WE}, {31'd0, exp_e.we});
        end
      end
      if (IN_VALID && IN_READY) begin
        sb.push_back('{data: ALU_RESULT, addr: RD_ADDR, we: RD_WE});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{4'b0100, 1'b1, 4'b0000, 3'b001, 4'b0100, 1'b1};
    vecs[1]  = '{4'b1000, 1'b1, 4'b1111, 3'b001, 4'b0100, 1'b1};
    vecs[2]  = '{4'b1000, 1'b0, 4'b0010, 3'b000, 4'b0100, 1'b1};
    vecs[3]  = '{4'b1000, 1'b1, 4'b0011, 3'b011, 4'b1000, 1'b1};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 3'b100, 4'b1000, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 3'b110, 4'b1000, 1'b0};
    vecs[6]  = '{4'b1001, 1'b1, 4'b0001, 3'b011, 4'b1001, 1'b0};
    vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 3'b100, 4'b1001, 1'b1};
    vecs[8]  = '{4'b0010, 1'b1, 4'b0100, 3'b111, 4'b0010, 1'b1};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 3'b010, 4'b0010, 1'b1};
    vecs[10] = '{4'b0100, 1'b1, 4'b0110, 3'b101, 4'b0100, 1'b1};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 3'b110, 4'b0100, 1'b0};
    vecs[12] = '{4'b0001, 1'b1, 4'b0101, 3'b101, 4'b0001, 1'b1};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 3'b111, 4'b0001, 1'b0};

    N_RST = 1'b0; IN_VALID = 1'b0; ALU_RESULT = '0; FLAG_IN = '0; S_ALU = '0;
    RD_ADDR = '0; RD_WE = 1'b0; FLAG_WE = 1'b0; OUT_READY = 1'b0; COND = 3'b000;

    // Reset state
    tick(); tick();
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    check("rst_wb_we", {31'd0, WB_WE}, 32'd0);
    check("rst_flag_reg", {28'd0, FLAG_REG}, 32'd0);
    check("rst_retire_cnt", {16'd0, RETIRE_CNT}, 32'd0);
    check("rst_cond_always", {31'd0, COND_TRUE}, 32'd1);
    COND = 3'b001; #1;
    check("rst_cond_eq", {31'd0, COND_TRUE}, 32'd0);
    COND = 3'b100; #1;
    check("rst_cond_ge", {31'd0, COND_TRUE}, 32'd1);
    N_RST = 1'b1;
    tick();

    // Single op
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; ALU_RESULT = 16'h1234; RD_ADDR = 3'd5; RD_WE = 1'b1;
    tick();
    IN_VALID = 1'b0;
    check("single_out_valid", {31'd0, OUT_VALID}, 32'd1);
    check("single_wb_data", {16'd0, WB_DATA}, 32'h1234);
    check("single_wb_addr", {29'd0, WB_ADDR}, 32'd5);
    check("single_wb_we", {31'd0, WB_WE}, 32'd1);
    tick();
    check("single_we_one_cycle", {31'd0, WB_WE}, 32'd0);
    check("single_retire_cnt", {16'd0, RETIRE_CNT}, 32'd1);

    // Backpressure: third push must be held while both slots are full
    OUT_READY = 1'b0; RD_ADDR = 3'd2;
    IN_VALID = 1'b1; ALU_RESULT = 16'h0001; tick();
    check("bp_ready_after_1", {31'd0, IN_READY}, 32'd1);
    ALU_RESULT = 16'h0002; tick();
    check("bp_ready_after_2", {31'd0, IN_READY}, 32'd0);
    ALU_RESULT = 16'h0003; tick(); tick();
    check("bp_hold_ready", {31'd0, IN_READY}, 32'd0);
    check("bp_hold_data", {16'd0, WB_DATA}, 32'h0001);
    OUT_READY = 1'b1; tick();
    check("bp_pop1_data", {16'd0, WB_DATA}, 32'h0002);
    tick();
    IN_VALID = 1'b0;
    check("bp_pop2_data", {16'd0, WB_DATA}, 32'h0003);
    tick();
    check("bp_drained", {31'd0, OUT_VALID}, 32'd0);
    check("bp_retire_cnt", {16'd0, RETIRE_CNT}, 32'd4);

    // Flag register and condition decode table
    for (int i = 0; i < 14; i++) begin
      IN_VALID = 1'b1; ALU_RESULT = 16'(16'h0100 + i); RD_ADDR = 3'(i); RD_WE = i[0];
      FLAG_IN = vecs[i].flag_in; FLAG_WE = vecs[i].flag_we; S_ALU = vecs[i].s_alu;
      COND = vecs[i].cond;
      tick();
      IN_VALID = 1'b0; FLAG_WE = 1'b0;
      check($sformatf("vec%0d_flags", i), {28'd0, FLAG_REG}, {28'd0, vecs[i].exp_flags});
      check($sformatf("vec%0d_cond", i), {31'd0, COND_TRUE}, {31'd0, vecs[i].exp_cond});
      tick();
    end
    check("vec_retire_cnt", {16'd0, RETIRE_CNT}, 32'd18);

    // Reset while in TWO discards both entries
    OUT_READY = 1'b0; RD_WE = 1'b1;
    IN_VALID = 1'b1; ALU_RESULT = 16'hAAAA; tick();
    ALU_RESULT = 16'hBBBB; tick();
    IN_VALID = 1'b0;
    check("two_in_ready", {31'd0, IN_READY}, 32'd0);
    check("two_wb_we", {31'd0, WB_WE}, 32'd1);
    #2 N_RST = 1'b0;
    #1;
    check("rst2_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst2_wb_we", {31'd0, WB_WE}, 32'd0);
    check("rst2_in_ready", {31'd0, IN_READY}, 32'd1);
    check("rst2_flag_reg", {28'd0, FLAG_REG}, 32'd0);
    check("rst2_retire_cnt", {16'd0, RETIRE_CNT}, 32'd0);
    tick();
    N_RST = 1'b1;
    OUT_READY = 1'b1;
    tick();
    check("rst2_no_wb_after", {31'd0, WB_WE}, 32'd0);

    // Counter wrap: 65535 pops reach 0xFFFF, one more wraps to 0
    IN_VALID = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      ALU_RESULT = 16'(i); RD_ADDR = 3'(i); RD_WE = i[1];
      tick();
    end
    IN_VALID = 1'b0;
    tick();
    check("wrap_cnt_ffff", {16'd0, RETIRE_CNT}, 32'h0000FFFF);
    IN_VALID = 1'b1; ALU_RESULT = 16'h5A5A; tick();
    IN_VALID = 1'b0; tick();
    check("wrap_cnt_zero", {16'd0, RETIRE_CNT}, 32'd0);
    check("sb_empty_at_end", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
